// File: rtl/fft_axi_host.sv
// rtl/fft_axi_host.sv - streams one frame from source RAM to the FFT bridge and stores the results
// Optional result watchdog enabled by defining FFT_HOST_TIMEOUT_EN.
module fft_axi_host #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_START,
  input  logic [ADDR_WIDTH-1:0] i_SAMPLES_NUMBER,
  output logic [ADDR_WIDTH-1:0] o_SRC_ADR,
  input  logic [DATA_WIDTH-1:0] i_SRC_DATA,
  output logic                  o_ARVALID,
  output logic [DATA_WIDTH-1:0] o_ARDATA,
  input  logic                  i_ARREADY,
  input  logic                  i_AWVALID,
  input  logic [DATA_WIDTH-1:0] i_AWDATA,
  output logic                  o_AWREADY,
  output logic [ADDR_WIDTH-1:0] o_DST_ADR,
  output logic [DATA_WIDTH-1:0] o_DST_DATA,
  output logic                  o_DST_WRITE,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_ERROR
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RES, RECV, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] n_reg;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [ADDR_WIDTH-1:0] snd_cnt;
  logic [ADDR_WIDTH-1:0] rcv_cnt;
  logic [DATA_WIDTH-1:0] ar_data;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  ar_valid;
  logic                  skid_valid;
  logic                  rd_pend;
  logic                  start_ok;
  logic                  start_run;
  logic                  drain;
  logic                  load_out;
  logic                  rd_issue;
  logic                  rx_phase;
  logic                  accept;
  logic                  snd_last;
  logic                  rcv_last;
  logic                  tmo_hit;
  logic [1:0]            occ;

  always_comb begin
    start_ok  = (state == IDLE) && i_START;
    start_run = start_ok && (i_SAMPLES_NUMBER != '0);
    drain     = ar_valid && i_ARREADY;
    load_out  = !ar_valid || drain;
    rx_phase  = (state == WAIT_RES) || (state == RECV);
    accept    = rx_phase && i_AWVALID;
    snd_last  = drain && ((snd_cnt + CNT_ONE) == n_reg);
    rcv_last  = accept && ((rcv_cnt + CNT_ONE) == n_reg);
    // words held or in flight after this cycle's drain; never exceeds two
    occ       = {1'b0, ar_valid} + {1'b0, skid_valid} + {1'b0, rd_pend} - {1'b0, drain};
    rd_issue  = (state == SEND) && (rd_cnt != n_reg) && (occ < 2'd2);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:           if (i_START) state_nx = (i_SAMPLES_NUMBER == '0) ? DONE : SEND;
      SEND:           if (snd_last) state_nx = WAIT_RES;
      WAIT_RES, RECV: begin
        if (rcv_last || tmo_hit) state_nx = DONE;
        else if (accept)         state_nx = RECV;
      end
      DONE:           state_nx = IDLE;
      default:        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Address 0 is presented while idle, so an accepted start doubles as its read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      n_reg      <= '0;
      rd_cnt     <= '0;
      snd_cnt    <= '0;
      rcv_cnt    <= '0;
      rd_pend    <= 1'b0;
      ar_valid   <= 1'b0;
      ar_data    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      rd_pend <= rd_issue || start_run;
      if (start_ok) begin
        n_reg   <= i_SAMPLES_NUMBER;
        rd_cnt  <= start_run ? CNT_ONE : '0;
        snd_cnt <= '0;
        rcv_cnt <= '0;
      end else begin
        if (rd_issue)        rd_cnt  <= rd_cnt + CNT_ONE;
        if (state == DONE)   rd_cnt  <= '0;
        if (drain)           snd_cnt <= snd_cnt + CNT_ONE;
        if (accept)          rcv_cnt <= rcv_cnt + CNT_ONE;
      end

      if (skid_valid) begin
        if (load_out) begin
          ar_data    <= skid_data;
          ar_valid   <= 1'b1;
          skid_valid <= rd_pend;
          if (rd_pend) skid_data <= i_SRC_DATA;
        end
      end else if (rd_pend) begin
        if (load_out) begin
          ar_data  <= i_SRC_DATA;
          ar_valid <= 1'b1;
        end else begin
          skid_data  <= i_SRC_DATA;
          skid_valid <= 1'b1;
        end
      end else if (drain) begin
        ar_valid <= 1'b0;
      end
    end
  end

`ifdef FFT_HOST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign tmo_hit = rx_phase && !accept && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (!rx_phase || accept) tmo_cnt <= '0;
      else                     tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (start_ok)     err_q <= 1'b0;
      else if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign o_ERROR = err_q;
`else
  assign tmo_hit = 1'b0;
  assign o_ERROR = 1'b0;
`endif

  assign o_SRC_ADR   = rd_cnt;
  assign o_ARVALID   = ar_valid;
  assign o_ARDATA    = ar_data;
  assign o_AWREADY   = rx_phase;
  assign o_DST_ADR   = rcv_cnt;
  assign o_DST_DATA  = accept ? i_AWDATA : '0;
  assign o_DST_WRITE = accept;
  assign o_BUSY      = (state != IDLE);
  assign o_DONE      = (state == DONE);

endmodule

// File: doc/fft_axi_host.md
FFT_AXI_HOST -- requirements
Module: fft_axi_host

Interface
REQ-001 Parameter DATA_WIDTH, 32, sample width in bits.
REQ-002 Parameter ADDR_WIDTH, 12, source/destination RAM address width; also the width of i_SAMPLES_NUMBER.
REQ-003 Parameter TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only when FFT_HOST_TIMEOUT_EN is defined.
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 i_START  in  1  one-cycle pulse that starts a frame.
REQ-007 i_SAMPLES_NUMBER  in  ADDR_WIDTH  frame length N, latched on an accepted i_START.
REQ-008 o_SRC_ADR  out  ADDR_WIDTH  source RAM read address.
REQ-009 i_SRC_DATA  in  DATA_WIDTH  source RAM data, valid one cycle after o_SRC_ADR.
REQ-010 o_ARVALID / o_ARDATA / i_ARREADY  out/out/in  1/DATA_WIDTH/1  sample stream toward the FFT bridge.
REQ-011 i_AWVALID / i_AWDATA / o_AWREADY  in/in/out  1/DATA_WIDTH/1  result stream from the FFT bridge.
REQ-012 o_DST_ADR / o_DST_DATA / o_DST_WRITE  out  ADDR_WIDTH/DATA_WIDTH/1  destination RAM write port.
REQ-013 o_BUSY  out  1  high in every state except IDLE.
REQ-014 o_DONE  out  1  one-cycle pulse at frame end.
REQ-015 o_ERROR  out  1  sticky timeout flag; cleared by the next accepted i_START.

Function
REQ-016 The FSM SHALL have states IDLE, SEND, WAIT_RES, RECV, DONE.
REQ-017 In IDLE, i_START with N>0 SHALL latch N, clear both counters and go to SEND; i_START with N==0 SHALL go straight to DONE with no transfers.
REQ-018 i_START in any state other than IDLE SHALL be ignored.
REQ-019 In SEND, the block SHALL read source addresses 0..N-1 in order and present each word on o_ARDATA with o_ARVALID high.
REQ-020 Once o_ARVALID is high, o_ARVALID and o_ARDATA SHALL stay stable until a cycle with i_ARREADY high (transfer).
REQ-021 With i_ARREADY held high, the block SHALL sustain one transfer per cycle after a 2-cycle initial latency from i_START, using a prefetch/skid buffer of at most two entries.
REQ-022 After the Nth transfer, o_ARVALID SHALL deassert on the next cycle and the FSM SHALL enter WAIT_RES.
REQ-023 o_AWREADY SHALL be high only in WAIT_RES and RECV; the first i_AWVALID&o_AWREADY SHALL move WAIT_RES to RECV.
REQ-024 Each i_AWVALID&o_AWREADY cycle SHALL write i_AWDATA to o_DST_ADR = receive count in the same cycle (o_DST_WRITE high) and then increment the count.
REQ-025 After the Nth received word, o_AWREADY SHALL drop on the next cycle, the FSM SHALL enter DONE, pulse o_DONE for one cycle and return to IDLE.
REQ-026 i_AWVALID while in IDLE or SEND SHALL be neither accepted nor written.
REQ-027 Counters SHALL be ADDR_WIDTH bits wide; N = 2^ADDR_WIDTH-1 SHALL complete without wrap.

Reset
REQ-028 When i_rst is asserted, the block SHALL asynchronously force IDLE and drive 0 on every output, including o_SRC_ADR, o_ARDATA and o_DST_ADR.
REQ-029 A reset during a frame SHALL abandon the frame with no o_DONE pulse; the first i_START after reset release SHALL run a full frame.

Configuration
REQ-030 When macro FFT_HOST_TIMEOUT_EN is defined, a counter SHALL run in WAIT_RES and RECV and clear on each accepted result word; on reaching TIMEOUT_CYCLES it SHALL set o_ERROR, enter DONE and pulse o_DONE.
REQ-031 When FFT_HOST_TIMEOUT_EN is not defined, o_ERROR SHALL be tied to 0 and the block SHALL wait in WAIT_RES and RECV indefinitely.

Verification
REQ-032 Test 1: source RAM[i]=i+1, N=10, i_ARREADY=1, bridge returns 2*x -> 10 back-to-back transfers with ARDATA 1..10; destination RAM[0..9]=2..20; one o_DONE pulse.
REQ-033 Test 2: i_ARREADY toggled 1,0,0,1 repeatedly, N=8 -> o_ARDATA stable across each stall; exactly 8 transfers in order; no duplicates or drops.
REQ-034 Test 3: N=0 start -> o_DONE pulse 1 cycle later; o_ARVALID, o_AWREADY and o_DST_WRITE stay 0.
REQ-035 Test 4: i_rst pulse after 4 of 10 samples are sent -> all outputs 0 immediately; no o_DONE; a following N=10 frame completes correctly.
REQ-036 Test 5: with FFT_HOST_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, no i_AWVALID after SEND -> o_ERROR=1 and o_DONE pulse 16 cycles after entering WAIT_RES.
REQ-037 Test 6: i_START pulsed during SEND, and i_AWVALID=1 during SEND -> both ignored; no destination write before WAIT_RES.
